fp_mul: RTL and testbench

FP_MUL -- requirements
Module: fp_mul

---
 rtl/fp_mul_if.sv | 21 ++
 rtl/fp_mul.sv | 121 ++++++++++++
 tb/tb_fp_mul.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/fp_mul_if.sv
// Operand/result bundle for fp_mul: operand strobe in, product and status out.
interface fp_mul_if #(
  parameter int unsigned WIDTH = 32
);
  logic [WIDTH-1:0] dataa;
  logic [WIDTH-1:0] datab;
  logic             data_valid;
  logic             busy;
  logic             result_valid;
  logic [WIDTH-1:0] result;

  modport master (
    output dataa, datab, data_valid,
    input  busy, result_valid, result
  );

  modport slave (
    input  dataa, datab, data_valid,
    output busy, result_valid, result
  );
endinterface

// File: rtl/fp_mul.sv
// Sequential shift-add floating-point multiplier: fixed MANT+3 cycle latency,
// truncating normalisation, no special-value handling.
module fp_mul #(
  parameter int unsigned EXP   = 8,
  parameter int unsigned MANT  = 23,
  parameter int unsigned WIDTH = 1 + EXP + MANT
) (
  input  logic    clock,
  input  logic    clock_sreset_n,
  fp_mul_if.slave bus
);

  localparam int unsigned PW = 2 * MANT + 2;
  localparam int unsigned CW = $clog2(MANT + 1);
  localparam logic [EXP-1:0] BIAS = EXP'((1 << (EXP - 1)) - 1);

  typedef enum logic [1:0] {IDLE, SETUP, MULT, NORM} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_sign;
  logic             r_zero;
  logic [EXP-1:0]   r_exp;
  logic [MANT:0]    r_ma;
  logic [MANT:0]    r_mb;
  logic [PW-1:0]    r_p;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_result_valid;
  logic [WIDTH-1:0] r_result;

  logic [EXP-1:0]   w_a_exp;
  logic [EXP-1:0]   w_b_exp;
  logic [PW-1:0]    w_addend;
  logic [EXP-1:0]   w_norm_exp;
  logic [MANT-1:0]  w_norm_mant;
  logic [WIDTH-1:0] w_product;

  assign w_a_exp  = r_a[MANT +: EXP];
  assign w_b_exp  = r_b[MANT +: EXP];
  assign w_addend = r_mb[r_cnt] ? (PW'(r_ma) << r_cnt) : '0;

  // State register
  always_ff @(posedge clock) begin
    if (!clock_sreset_n) r_state <= IDLE;
    else                 r_state <= w_next;
  end

  // Next-state logic; data_valid only matters while idle
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.data_valid) w_next = SETUP;
      SETUP:   w_next = MULT;
      MULT:    if (r_cnt == CW'(MANT)) w_next = NORM;
      NORM:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Product in [1,4): shift right by one and bump exponent when the top bit is set
  always_comb begin
    w_norm_exp  = r_exp;
    w_norm_mant = r_p[2*MANT-1 -: MANT];
    if (r_p[PW-1]) begin
      w_norm_exp  = r_exp + EXP'(1);
      w_norm_mant = r_p[2*MANT -: MANT];
    end
    if (r_zero) w_product = WIDTH'({r_sign, {(WIDTH-1){1'b0}}});
    else        w_product = WIDTH'({r_sign, w_norm_exp, w_norm_mant});
  end

  // Datapath and registered outputs
  always_ff @(posedge clock) begin
    if (!clock_sreset_n) begin
      r_a            <= '0;
      r_b            <= '0;
      r_sign         <= 1'b0;
      r_zero         <= 1'b0;
      r_exp          <= '0;
      r_ma           <= '0;
      r_mb           <= '0;
      r_p            <= '0;
      r_cnt          <= '0;
      r_busy         <= 1'b0;
      r_result_valid <= 1'b0;
      r_result       <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_a <= bus.dataa;
          r_b <= bus.datab;
        end
        SETUP: begin
          r_sign <= r_a[WIDTH-1] ^ r_b[WIDTH-1];
          r_zero <= (w_a_exp == '0) || (w_b_exp == '0);
          r_exp  <= w_a_exp + w_b_exp - BIAS;
          r_ma   <= {1'b1, r_a[MANT-1:0]};
          r_mb   <= {1'b1, r_b[MANT-1:0]};
          r_p    <= '0;
          r_cnt  <= '0;
        end
        MULT: begin
          r_p   <= r_p + w_addend;
          r_cnt <= r_cnt + CW'(1);
        end
        NORM:    r_result <= w_product;
        default: ;
      endcase
      r_result_valid <= (r_state == NORM);
      r_busy         <= (w_next != IDLE);
    end
  end

  assign bus.busy         = r_busy;
  assign bus.result_valid = r_result_valid;
  assign bus.result       = r_result;

endmodule

// File: tb/tb_fp_mul.sv
// Directed self-checking bench for fp_mul: latency, normalisation, zero,
// busy-ignore, mid-operation reset and back-to-back requests.
module tb_fp_mul;

  localparam int unsigned EXP   = 8;
  localparam int unsigned MANT  = 23;
  localparam int unsigned WIDTH = 32;
  localparam int          LAT   = MANT + 3;

  logic clock = 1'b0;
  logic clock_sreset_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  fp_mul_if #(.WIDTH(WIDTH)) bus ();

  fp_mul #(.EXP(EXP), .MANT(MANT), .WIDTH(WIDTH)) dut (
    .clock          (clock),
    .clock_sreset_n (clock_sreset_n),
    .bus            (bus)
  );

  // Present operands for exactly one sampling edge, then scramble them
  task automatic drive_op(input logic [31:0] a, input logic [31:0] b);
    bus.dataa      = a;
    bus.datab      = b;
    bus.data_valid = 1'b1;
    @(posedge clock); #1;
    bus.data_valid = 1'b0;
    bus.dataa      = $urandom;
    bus.datab      = $urandom;
  endtask

  // Wait for result_valid; lat=-1 on timeout; ok=0 if busy dropped or result moved early
  task automatic wait_result(output logic [31:0] res, output int lat, output bit ok);
    logic [31:0] held;
    held = bus.result;
    lat  = -1;
    ok   = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clock); #1;
      if (bus.result_valid) begin
        lat = i;
        break;
      end
      if (bus.result !== held || bus.busy !== 1'b1) ok = 1'b0;
    end
    res = bus.result;
  endtask

  task automatic count_pulses(input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clock); #1;
      if (bus.result_valid) cnt++;
    end
  endtask

  task automatic test_reset;
    clock_sreset_n = 1'b0;
    bus.data_valid = 1'b0;
    bus.dataa      = '0;
    bus.datab      = '0;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.result_valid !== 1'b0 || bus.result !== 32'h0) begin
      errors++;
      $display("FAIL reset: busy=%b rv=%b result=%h, want 0 0 00000000",
               bus.busy, bus.result_valid, bus.result);
    end
    clock_sreset_n = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_products;
    logic [31:0] va [8];
    logic [31:0] vb [8];
    logic [31:0] ve [8];
    logic [31:0] res;
    int          lat;
    bit          ok;
    va = '{32'h40000000, 32'h3FC00000, 32'hC0000000, 32'h00000000,
           32'h80000000, 32'h3F800001, 32'h7F000000, 32'h00400000};
    vb = '{32'h40400000, 32'h3FC00000, 32'h3F000000, 32'h40490FDB,
           32'h3F800000, 32'h3F800001, 32'h7F000000, 32'h3F800000};
    ve = '{32'h40C00000, 32'h40100000, 32'hBF800000, 32'h00000000,
           32'h80000000, 32'h3F800002, 32'h3E800000, 32'h00000000};
    for (int i = 0; i < 8; i++) begin
      drive_op(va[i], vb[i]);
      wait_result(res, lat, ok);
      checks++;
      if (res !== ve[i]) begin
        errors++;
        $display("FAIL product[%0d] %h*%h: got %h, want %h", i, va[i], vb[i], res, ve[i]);
      end
      checks++;
      if (lat != LAT || !ok) begin
        errors++;
        $display("FAIL latency[%0d]: got %0d cycles busy_ok=%b, want %0d busy_ok=1",
                 i, lat, ok, LAT);
      end
      @(posedge clock); #1;
      checks++;
      if (bus.result_valid !== 1'b0 || bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL pulse_width[%0d]: rv=%b busy=%b after pulse, want 0 0",
                 i, bus.result_valid, bus.busy);
      end
    end
  endtask

  task automatic test_busy_ignore;
    logic [31:0] res;
    int          lat;
    int          cnt;
    bit          ok;
    drive_op(32'h40000000, 32'h40400000);
    repeat (4) @(posedge clock);
    #1;
    drive_op(32'h3FC00000, 32'h3FC00000);
    wait_result(res, lat, ok);
    checks++;
    if (res !== 32'h40C00000 || lat != LAT - 5 || !ok) begin
      errors++;
      $display("FAIL busy_ignore: result=%h lat=%0d ok=%b, want 40c00000 %0d 1",
               res, lat, ok, LAT - 5);
    end
    count_pulses(40, cnt);
    checks++;
    if (cnt != 0) begin
      errors++;
      $display("FAIL busy_ignore_pulses: got %0d extra pulses, want 0", cnt);
    end
  endtask

  task automatic test_reset_mid_op;
    logic [31:0] res;
    int          lat;
    int          cnt;
    bit          ok;
    drive_op(32'h3FC00000, 32'h3FC00000);
    repeat (9) @(posedge clock);
    #1;
    clock_sreset_n = 1'b0;
    @(posedge clock); #1;
    clock_sreset_n = 1'b1;
    checks++;
    if (bus.busy !== 1'b0 || bus.result_valid !== 1'b0 || bus.result !== 32'h0) begin
      errors++;
      $display("FAIL mid_reset: busy=%b rv=%b result=%h, want 0 0 00000000",
               bus.busy, bus.result_valid, bus.result);
    end
    count_pulses(40, cnt);
    checks++;
    if (cnt != 0) begin
      errors++;
      $display("FAIL mid_reset_pulses: got %0d pulses, want 0", cnt);
    end
    drive_op(32'h40000000, 32'h40400000);
    wait_result(res, lat, ok);
    checks++;
    if (res !== 32'h40C00000 || lat != LAT) begin
      errors++;
      $display("FAIL after_reset: result=%h lat=%0d, want 40c00000 %0d", res, lat, LAT);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] res;
    int          lat;
    bit          ok;
    drive_op(32'hC0000000, 32'h3F000000);
    wait_result(res, lat, ok);
    checks++;
    if (res !== 32'hBF800000 || lat != LAT) begin
      errors++;
      $display("FAIL b2b_first: result=%h lat=%0d, want bf800000 %0d", res, lat, LAT);
    end
    drive_op(32'h3FC00000, 32'h3FC00000);
    wait_result(res, lat, ok);
    checks++;
    if (res !== 32'h40100000 || lat != LAT || !ok) begin
      errors++;
      $display("FAIL b2b_second: result=%h lat=%0d ok=%b, want 40100000 %0d 1",
               res, lat, ok, LAT);
    end
  endtask

  initial begin
    test_reset();
    test_products();
    test_busy_ignore();
    test_reset_mid_op();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
